// File: rtl/ariane_pkg.sv
// ariane_pkg: shared fetch types, buffer depth and fetch FSM states.
// Provides branchpredict_sbe_t (alias branch_predict_sbe_t), fetch_entry_t,
// FETCH_FIFO_DEPTH and fetch_state_e for fetch_unit and fetch_fifo.
package ariane_pkg;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;
  typedef struct packed {
    logic        valid;
    logic [63:0] predict_address;
    logic        predict_taken;
  } branchpredict_sbe_t;
  typedef branchpredict_sbe_t branch_predict_sbe_t;
  typedef struct packed {
    logic [63:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
  } fetch_entry_t;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetch entries between the I-cache and decode.
// Ports: clk_i/rst_ni (async active-low), flush_i empties the buffer and wins
// over push_i/pop_i, data_i/data_o entry in/oldest entry out,
// full_o/empty_o/count_o occupancy. pop_i is ignored while empty.
module fetch_fifo import ariane_pkg::*; #(
  parameter int unsigned DEPTH = FETCH_FIFO_DEPTH,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  output fetch_entry_t  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          pop;
  assign pop     = pop_i && !empty_o;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues one I-cache request at a time and buffers responses for decode.
// Ports: clk_i/rst_ni (async active-low), flush_i, fetch_address_i/fetch_valid_i/
// branch_predict_i from the PC generator, if_ready_o acceptance, instr_req_o/
// instr_addr_o/instr_gnt_i/instr_rvalid_i/instr_rdata_i cache handshake,
// fetch_entry_o/fetch_entry_valid_o/fetch_ack_i to decode, perf_stall_cnt_o.
// Define FETCH_PERF_CNT_EN to build the back-pressure stall counter; otherwise
// perf_stall_cnt_o is tied to zero.
module fetch_unit import ariane_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [63:0]        fetch_address_i,
  input  logic               fetch_valid_i,
  input  branchpredict_sbe_t branch_predict_i,
  output logic               if_ready_o,
  output logic               instr_req_o,
  output logic [63:0]        instr_addr_o,
  input  logic               instr_gnt_i,
  input  logic               instr_rvalid_i,
  input  logic [31:0]        instr_rdata_i,
  output fetch_entry_t       fetch_entry_o,
  output logic               fetch_entry_valid_o,
  input  logic               fetch_ack_i,
  output logic [31:0]        perf_stall_cnt_o
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(FIFO_DEPTH - 1);
  fetch_state_e       state_q, state_d;
  logic               aborted_q, aborted_d;
  logic [63:0]        addr_q, addr_d;
  branchpredict_sbe_t bp_q, bp_d;
  logic               push, issue, full, empty;
  logic [CW-1:0]      count;
  fetch_entry_t       push_entry;
  assign push_entry          = '{address: addr_q, instruction: instr_rdata_i, branch_predict: bp_q};
  assign fetch_entry_valid_o = !empty;
  always_comb begin
    state_d     = state_q;
    aborted_d   = aborted_q;
    addr_d      = addr_q;
    bp_d        = bp_q;
    if_ready_o  = 1'b0;
    instr_req_o = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: if_ready_o = !full && !flush_i;
      WAIT_GNT: begin
        instr_req_o = 1'b1;
        if (flush_i) aborted_d = 1'b1;
        if (instr_gnt_i) begin
          state_d   = (aborted_q || flush_i) ? WAIT_ABORTED : WAIT_RVALID;
          aborted_d = 1'b0;
        end
      end
      WAIT_RVALID: begin
        if (flush_i) state_d = instr_rvalid_i ? IDLE : WAIT_ABORTED;
        else if (instr_rvalid_i) begin
          push       = 1'b1;
          state_d    = IDLE;
          // The new request must still fit once this response is in the buffer.
          if_ready_o = count < LAST;
        end
      end
      WAIT_ABORTED: if (instr_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    issue = fetch_valid_i && if_ready_o;
    if (issue) begin
      instr_req_o = 1'b1;
      addr_d      = fetch_address_i;
      bp_d        = branch_predict_i;
      state_d     = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
    end
    instr_addr_o = {(issue ? fetch_address_i[63:2] : addr_q[63:2]), 2'b00};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      aborted_q <= 1'b0;
      addr_q    <= '0;
      bp_q      <= '0;
    end else begin
      state_q   <= state_d;
      aborted_q <= aborted_d;
      addr_q    <= addr_d;
      bp_q      <= bp_d;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (fetch_ack_i),
    .data_o  (fetch_entry_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else if (fetch_valid_i && !if_ready_o && !flush_i) stall_q <= stall_q + 32'd1;
  end
  assign perf_stall_cnt_o = stall_q;
`else
  assign perf_stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run against a queue-based reference model.
module tb_fetch_unit;
  import ariane_pkg::*;
  localparam int D = 2;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif
  logic               clk_i = 1'b0;
  logic               rst_ni, flush_i, fetch_valid_i, if_ready_o;
  logic               instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic               fetch_entry_valid_o, fetch_ack_i;
  logic [63:0]        fetch_address_i, instr_addr_o;
  logic [31:0]        instr_rdata_i, perf_stall_cnt_o;
  branchpredict_sbe_t branch_predict_i;
  fetch_entry_t       fetch_entry_o;
  int total = 0;
  int bad = 0;
  always #5 clk_i = ~clk_i;
  fetch_unit #(.FIFO_DEPTH(D)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .fetch_address_i     (fetch_address_i),
    .fetch_valid_i       (fetch_valid_i),
    .branch_predict_i    (branch_predict_i),
    .if_ready_o          (if_ready_o),
    .instr_req_o         (instr_req_o),
    .instr_addr_o        (instr_addr_o),
    .instr_gnt_i         (instr_gnt_i),
    .instr_rvalid_i      (instr_rvalid_i),
    .instr_rdata_i       (instr_rdata_i),
    .fetch_entry_o       (fetch_entry_o),
    .fetch_entry_valid_o (fetch_entry_valid_o),
    .fetch_ack_i         (fetch_ack_i),
    .perf_stall_cnt_o    (perf_stall_cnt_o)
  );
  function automatic branchpredict_sbe_t rnd_bp();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[65:0];
  endfunction
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction
  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
  endfunction
  task automatic idle_inputs();
    flush_i = 0; fetch_valid_i = 0; fetch_address_i = '0; branch_predict_i = '0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0; fetch_ack_i = 0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst_ni = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    @(negedge clk_i); #1;
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", instr_req_o); end
    total++; if (fetch_entry_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", fetch_entry_valid_o); end
    total++; if (perf_stall_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_perf: got %0d want 0", perf_stall_cnt_o); end
    rst_ni = 1;
    @(negedge clk_i); #1;
    total++; if (if_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", if_ready_o); end
  endtask

  task automatic test_basic();
    branchpredict_sbe_t bp;
    fetch_entry_t exp;
    do_reset();
    bp = rnd_bp();
    exp = '{address: 64'h8000_0002, instruction: 32'h0000_0013, branch_predict: bp};
    @(negedge clk_i);
    fetch_valid_i = 1; fetch_address_i = 64'h8000_0002; branch_predict_i = bp; instr_gnt_i = 1;
    #1;
    total++; if (instr_req_o !== 1'b1) begin bad++; $display("FAIL basic_req: got %b want 1", instr_req_o); end
    total++; if (instr_addr_o !== 64'h8000_0000) begin bad++; $display("FAIL basic_addr: got %h want 80000000", instr_addr_o); end
    @(negedge clk_i);
    fetch_valid_i = 0; instr_gnt_i = 0; branch_predict_i = rnd_bp(); fetch_address_i = rnd64();
    instr_rvalid_i = 1; instr_rdata_i = 32'h0000_0013;
    #1;
    total++; if (fetch_entry_valid_o !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", fetch_entry_valid_o); end
    @(negedge clk_i);
    instr_rvalid_i = 0;
    #1;
    total++; if (fetch_entry_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", fetch_entry_valid_o); end
    total++; if (fetch_entry_o !== exp) begin bad++; $display("FAIL basic_entry: got %h want %h", fetch_entry_o, exp); end
    fetch_ack_i = 1;
    @(negedge clk_i);
    fetch_ack_i = 0;
    #1;
    total++; if (fetch_entry_valid_o !== 1'b0) begin bad++; $display("FAIL basic_pop: got %b want 0", fetch_entry_valid_o); end
  endtask

  task automatic test_gnt_delay();
    logic [63:0] a;
    logic [31:0] d;
    do_reset();
    a = rnd64();
    d = $urandom;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      fetch_valid_i = (c == 0); fetch_address_i = (c == 0) ? a : rnd64(); instr_gnt_i = (c == 3);
      #1;
      total++; if (instr_req_o !== 1'b1) begin bad++; $display("FAIL gntdly_req%0d: got %b want 1", c, instr_req_o); end
      total++; if (instr_addr_o !== {a[63:2], 2'b00}) begin bad++; $display("FAIL gntdly_addr%0d: got %h want %h", c, instr_addr_o, {a[63:2], 2'b00}); end
    end
    @(negedge clk_i);
    fetch_valid_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = d;
    #1;
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL gntdly_req_drop: got %b want 0", instr_req_o); end
    @(negedge clk_i);
    instr_rvalid_i = 0;
    #1;
    total++; if (fetch_entry_valid_o !== 1'b1 || fetch_entry_o.address !== a || fetch_entry_o.instruction !== d) begin
      bad++; $display("FAIL gntdly_entry: got v=%b %h/%h want 1 %h/%h", fetch_entry_valid_o, fetch_entry_o.address, fetch_entry_o.instruction, a, d);
    end
    fetch_ack_i = 1;
    @(negedge clk_i);
    fetch_ack_i = 0;
    #1;
    total++; if (fetch_entry_valid_o !== 1'b0) begin bad++; $display("FAIL gntdly_single: got %b want 0", fetch_entry_valid_o); end
  endtask

  task automatic test_flush_abort();
    do_reset();
    @(negedge clk_i);
    fetch_valid_i = 1; fetch_address_i = rnd64(); instr_gnt_i = 1;
    @(negedge clk_i);
    fetch_address_i = rnd64(); instr_rvalid_i = 1; instr_rdata_i = $urandom;
    #1;
    total++; if (instr_req_o !== 1'b1) begin bad++; $display("FAIL flush_b2b_req: got %b want 1", instr_req_o); end
    @(negedge clk_i);
    fetch_valid_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0; flush_i = 1;
    #1;
    total++; if (fetch_entry_valid_o !== 1'b1) begin bad++; $display("FAIL flush_pre_valid: got %b want 1", fetch_entry_valid_o); end
    total++; if (if_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", if_ready_o); end
    @(negedge clk_i);
    flush_i = 0;
    #1;
    total++; if (dut.state_q !== WAIT_ABORTED) begin bad++; $display("FAIL flush_state: got %0d want %0d", dut.state_q, WAIT_ABORTED); end
    total++; if (fetch_entry_valid_o !== 1'b0) begin bad++; $display("FAIL flush_empty: got %b want 0", fetch_entry_valid_o); end
    total++; if (if_ready_o !== 1'b0) begin bad++; $display("FAIL flush_aborted_ready: got %b want 0", if_ready_o); end
    @(negedge clk_i);
    instr_rvalid_i = 1; instr_rdata_i = $urandom;
    #1;
    total++; if (if_ready_o !== 1'b0) begin bad++; $display("FAIL flush_rvalid_ready: got %b want 0", if_ready_o); end
    @(negedge clk_i);
    instr_rvalid_i = 0;
    #1;
    total++; if (fetch_entry_valid_o !== 1'b0) begin bad++; $display("FAIL flush_no_push: got %b want 0", fetch_entry_valid_o); end
    total++; if (if_ready_o !== 1'b1) begin bad++; $display("FAIL flush_after_ready: got %b want 1", if_ready_o); end
  endtask

  task automatic test_back_to_back_full();
    logic [63:0] a0, a1;
    logic [31:0] d0, d1, exp_stall;
    do_reset();
    a0 = rnd64(); a1 = rnd64(); d0 = $urandom; d1 = $urandom;
    exp_stall = PERF_ON ? 32'd5 : 32'd0;
    @(negedge clk_i);
    fetch_valid_i = 1; fetch_address_i = a0; instr_gnt_i = 1;
    @(negedge clk_i);
    fetch_address_i = a1; instr_rvalid_i = 1; instr_rdata_i = d0;
    #1;
    total++; if (if_ready_o !== 1'b1 || instr_req_o !== 1'b1) begin bad++; $display("FAIL b2b_issue: got rdy=%b req=%b want 1 1", if_ready_o, instr_req_o); end
    total++; if (instr_addr_o !== {a1[63:2], 2'b00}) begin bad++; $display("FAIL b2b_addr: got %h want %h", instr_addr_o, {a1[63:2], 2'b00}); end
    @(negedge clk_i);
    fetch_address_i = rnd64(); instr_gnt_i = 0; instr_rdata_i = d1;
    #1;
    total++; if (if_ready_o !== 1'b0 || instr_req_o !== 1'b0) begin bad++; $display("FAIL full_no_issue: got rdy=%b req=%b want 0 0", if_ready_o, instr_req_o); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      instr_rvalid_i = 0; fetch_address_i = rnd64();
      #1;
      total++; if (if_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready%0d: got %b want 0", c, if_ready_o); end
    end
    @(negedge clk_i);
    fetch_valid_i = 0;
    #1;
    total++; if (perf_stall_cnt_o !== exp_stall) begin bad++; $display("FAIL full_perf: got %0d want %0d", perf_stall_cnt_o, exp_stall); end
    total++; if (fetch_entry_valid_o !== 1'b1 || fetch_entry_o.address !== a0 || fetch_entry_o.instruction !== d0) begin
      bad++; $display("FAIL full_entry0: got v=%b %h/%h want 1 %h/%h", fetch_entry_valid_o, fetch_entry_o.address, fetch_entry_o.instruction, a0, d0);
    end
    fetch_ack_i = 1;
    @(negedge clk_i);
    #1;
    total++; if (fetch_entry_valid_o !== 1'b1 || fetch_entry_o.address !== a1 || fetch_entry_o.instruction !== d1) begin
      bad++; $display("FAIL full_entry1: got v=%b %h/%h want 1 %h/%h", fetch_entry_valid_o, fetch_entry_o.address, fetch_entry_o.instruction, a1, d1);
    end
    @(negedge clk_i);
    fetch_ack_i = 0;
    #1;
    total++; if (fetch_entry_valid_o !== 1'b0) begin bad++; $display("FAIL full_drained: got %b want 0", fetch_entry_valid_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk_i);
    fetch_valid_i = 1; fetch_address_i = rnd64(); instr_gnt_i = 1;
    @(negedge clk_i);
    fetch_valid_i = 0; instr_gnt_i = 0; rst_ni = 0;
    #1;
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL rstmid_req: got %b want 0", instr_req_o); end
    @(negedge clk_i);
    rst_ni = 1; instr_rvalid_i = 1; instr_rdata_i = $urandom;
    #1;
    total++; if (if_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", if_ready_o); end
    @(negedge clk_i);
    instr_rvalid_i = 0;
    #1;
    total++; if (fetch_entry_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_no_push: got %b want 0", fetch_entry_valid_o); end
  endtask

  task automatic test_random();
    fetch_entry_t       q[$];
    fetch_entry_t       e;
    bit                 busy = 0, granted = 0, aborted = 0, rv, exp_ready, exp_req;
    logic [63:0]        p_addr = '0, exp_addr;
    branchpredict_sbe_t p_bp = '0;
    int                 wait_cnt = 0;
    logic [31:0]        stall = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      flush_i          = ($urandom_range(0, 19) == 0);
      fetch_valid_i    = ($urandom_range(0, 9) < 7);
      fetch_address_i  = rnd64();
      branch_predict_i = rnd_bp();
      fetch_ack_i      = ($urandom_range(0, 1) == 1);
      rv               = busy && granted && wait_cnt == 0;
      instr_rvalid_i   = rv;
      instr_rdata_i    = rv ? mem_data(p_addr) : $urandom;
      instr_gnt_i      = 0;
      #1;
      instr_gnt_i = instr_req_o && ($urandom_range(0, 9) < 6);
      #1;
      // Readiness: nothing outstanding and room, or a live response arriving with room for one more.
      exp_ready = !flush_i && (busy ? (granted && !aborted && rv && q.size() + 1 < D) : q.size() < D);
      exp_req   = (busy && !granted) || (fetch_valid_i && exp_ready);
      exp_addr  = (busy && !granted) ? p_addr : fetch_address_i;
      exp_addr[1:0] = 2'b00;
      total++; if (if_ready_o !== exp_ready) begin bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, if_ready_o, exp_ready); end
      total++; if (instr_req_o !== exp_req) begin bad++; $display("FAIL rnd_req c%0d: got %b want %b", c, instr_req_o, exp_req); end
      if (exp_req) begin
        total++; if (instr_addr_o !== exp_addr) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", c, instr_addr_o, exp_addr); end
      end
      total++; if (fetch_entry_valid_o !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, fetch_entry_valid_o, q.size() > 0); end
      if (q.size() > 0) begin
        total++; if (fetch_entry_o !== q[0]) begin bad++; $display("FAIL rnd_entry c%0d: got %h want %h", c, fetch_entry_o, q[0]); end
      end
      total++; if (perf_stall_cnt_o !== (PERF_ON ? stall : 32'd0)) begin bad++; $display("FAIL rnd_perf c%0d: got %0d want %0d", c, perf_stall_cnt_o, PERF_ON ? stall : 32'd0); end
      if (fetch_valid_i && !exp_ready && !flush_i) stall = stall + 32'd1;
      if (fetch_ack_i && q.size() > 0) void'(q.pop_front());
      if (rv) begin
        if (!aborted && !flush_i) begin
          e = '{address: p_addr, instruction: instr_rdata_i, branch_predict: p_bp};
          q.push_back(e);
        end
        busy = 0;
      end else if (busy && granted) wait_cnt--;
      if (flush_i) begin
        q.delete();
        if (busy) aborted = 1;
      end
      if (busy && !granted && instr_gnt_i) begin
        granted = 1;
        wait_cnt = $urandom_range(0, 2);
      end
      if (fetch_valid_i && exp_ready) begin
        busy = 1; aborted = 0; granted = instr_gnt_i;
        p_addr = fetch_address_i; p_bp = branch_predict_i;
        wait_cnt = $urandom_range(0, 2);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gnt_delay();
    test_flush_abort();
    test_back_to_back_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
